// File: rtl/pcie_us_cfg_mgmt_resp.sv
// rtl/pcie_us_cfg_mgmt_resp.sv - cfg_mgmt completer: small dword config space with programmable response latency
module pcie_us_cfg_mgmt_resp #(
  parameter int          MEM_DEPTH = 64,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] ID_VALUE  = 32'h0001_1234,
  parameter logic [31:0] CLASS_REV = 32'h0580_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic        stat_busy,
  output logic        stat_proto_err
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [10:0] DEPTH_LIM = 11'(MEM_DEPTH);
  localparam logic [7:0]  CNT_LOAD  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [9:0]  lat_addr;
  logic [7:0]  lat_func;
  logic [31:0] lat_data;
  logic [3:0]  lat_be;
  logic        lat_write;
  logic [31:0] mem [MEM_DEPTH];

  logic          req;
  logic          accept;
  logic          hit;
  logic          writable;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;

  assign req      = cfg_mgmt_read | cfg_mgmt_write;
  assign accept   = (state == S_IDLE) && req;
  assign hit      = (lat_func == 8'd0) && ({1'b0, lat_addr} < DEPTH_LIM);
  assign idx      = lat_addr[AW-1:0];
  assign writable = hit && (lat_addr != 10'd0) && (lat_addr != 10'd2);

  always_comb begin
    rd_word = '0;
    if (hit) begin
      if (lat_addr == 10'd0)      rd_word = ID_VALUE;
      else if (lat_addr == 10'd2) rd_word = CLASS_REV;
      else                        rd_word = mem[idx];
    end
  end

  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (lat_be[b]) merged[8*b +: 8] = lat_data[8*b +: 8];
    end
  end

  // The counter reaches 0 on the edge that enters DONE, so done lands LATENCY edges after accept.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (req) state_next = (LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT:    if (cnt == 8'd1) state_next = S_DONE;
      S_DONE:    state_next = S_RELEASE;
      S_RELEASE: if (!req) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == S_WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // A collision is served as a write: write wins the direction latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_func  <= '0;
      lat_data  <= '0;
      lat_be    <= '0;
      lat_write <= 1'b0;
    end else if (accept) begin
      lat_addr  <= cfg_mgmt_addr;
      lat_func  <= cfg_mgmt_function_number;
      lat_data  <= cfg_mgmt_write_data;
      lat_be    <= cfg_mgmt_byte_enable;
      lat_write <= cfg_mgmt_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (state == S_DONE && lat_write && writable) begin
      mem[idx] <= merged;
    end
  end

  // read_data samples storage on the same edge a write commits, so it sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mgmt_read_data       <= '0;
      cfg_mgmt_read_write_done <= 1'b0;
      stat_busy                <= 1'b0;
      stat_proto_err           <= 1'b0;
    end else begin
      cfg_mgmt_read_data       <= (state == S_DONE && !lat_write) ? rd_word : 32'd0;
      cfg_mgmt_read_write_done <= (state == S_DONE);
      stat_busy                <= (state_next != S_IDLE);
      stat_proto_err           <= accept && cfg_mgmt_read && cfg_mgmt_write;
    end
  end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_resp.sv
// tb/tb_pcie_us_cfg_mgmt_resp.sv - bench for pcie_us_cfg_mgmt_resp, LATENCY=4 and LATENCY=1 instances
module tb_pcie_us_cfg_mgmt_resp;

  localparam logic [31:0] ID = 32'h0001_1234;
  localparam logic [31:0] CR = 32'h0580_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0]  addr_s [2];
  logic [7:0]  func_s [2];
  logic [31:0] wd_s   [2];
  logic [3:0]  be_s   [2];
  logic [1:0]  rd_s, wr_s;
  logic [31:0] rdata_s [2];
  logic [1:0]  done_s, busy_s, perr_s;

  int total = 0;
  int bad   = 0;
  int lat_of [2];
  logic [31:0] mm [2][64];

  always #5 clk = ~clk;

  pcie_us_cfg_mgmt_resp #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .cfg_mgmt_addr(addr_s[0]), .cfg_mgmt_function_number(func_s[0]),
    .cfg_mgmt_write(wr_s[0]), .cfg_mgmt_write_data(wd_s[0]), .cfg_mgmt_byte_enable(be_s[0]),
    .cfg_mgmt_read(rd_s[0]), .cfg_mgmt_read_data(rdata_s[0]), .cfg_mgmt_read_write_done(done_s[0]),
    .stat_busy(busy_s[0]), .stat_proto_err(perr_s[0]));

  pcie_us_cfg_mgmt_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .cfg_mgmt_addr(addr_s[1]), .cfg_mgmt_function_number(func_s[1]),
    .cfg_mgmt_write(wr_s[1]), .cfg_mgmt_write_data(wd_s[1]), .cfg_mgmt_byte_enable(be_s[1]),
    .cfg_mgmt_read(rd_s[1]), .cfg_mgmt_read_data(rdata_s[1]), .cfg_mgmt_read_write_done(done_s[1]),
    .stat_busy(busy_s[1]), .stat_proto_err(perr_s[1]));

  function automatic void model_clear();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) mm[u][i] = '0;
  endfunction

  function automatic logic [31:0] model_read(int u, logic [9:0] a, logic [7:0] f);
    if (f != 8'd0 || a >= 10'd64) return '0;
    if (a == 10'd0) return ID;
    if (a == 10'd2) return CR;
    return mm[u][a[5:0]];
  endfunction

  function automatic void model_write(int u, logic [9:0] a, logic [7:0] f, logic [31:0] d, logic [3:0] b);
    if (f != 8'd0 || a >= 10'd64 || a == 10'd0 || a == 10'd2) return;
    for (int i = 0; i < 4; i++)
      if (b[i]) mm[u][a[5:0]][8*i +: 8] = d[8*i +: 8];
  endfunction

  // Drives one request, scrambles the non-direction inputs after accept, returns done latency (-1 = none).
  task automatic do_txn(input int u, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [7:0] f, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rdata, output int lat, output logic perr);
    @(negedge clk);
    addr_s[u] = a; func_s[u] = f; wd_s[u] = d; be_s[u] = b; rd_s[u] = rd; wr_s[u] = wr;
    @(posedge clk); #1;
    perr = perr_s[u];
    addr_s[u] = 10'($urandom); func_s[u] = 8'($urandom); wd_s[u] = $urandom; be_s[u] = 4'($urandom);
    lat = -1;
    rdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_s[u]) begin
        lat = k;
        rdata = rdata_s[u];
        break;
      end
    end
    @(negedge clk);
    rd_s[u] = 1'b0; wr_s[u] = 1'b0;
    for (int k = 0; k < 10 && busy_s[u]; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r; int l; logic p;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      total++; if (done_s[u] !== 1'b0) begin bad++; $display("FAIL reset_done u%0d got=%b want=0", u, done_s[u]); end
      total++; if (busy_s[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d got=%b want=0", u, busy_s[u]); end
      total++; if (perr_s[u] !== 1'b0) begin bad++; $display("FAIL reset_perr u%0d got=%b want=0", u, perr_s[u]); end
      total++; if (rdata_s[u] !== 32'd0) begin bad++; $display("FAIL reset_rdata u%0d got=%h want=0", u, rdata_s[u]); end
    end
    do_txn(0, 1'b0, 1'b1, 10'd5, 8'd0, 32'hDEAD_BEEF, 4'hF, r, l, p);
    model_write(0, 10'd5, 8'd0, 32'hDEAD_BEEF, 4'hF);
    do_txn(0, 1'b1, 1'b0, 10'd5, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pre_reset_read got=%h want=deadbeef", r); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_clear();
    do_txn(0, 1'b1, 1'b0, 10'd5, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL post_reset_read got=%h want=0", r); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    addr_s[0] = 10'd4; func_s[0] = 8'd0; rd_s[0] = 1'b1; wr_s[0] = 1'b0;
    @(posedge clk); #1;
    total++; if (busy_s[0] !== 1'b1) begin bad++; $display("FAIL mid_busy_accept got=%b want=1", busy_s[0]); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL mid_busy_reset got=%b want=0", busy_s[0]); end
    @(negedge clk); rd_s[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_clear();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_s[0]) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", pulses); end
  endtask

  task automatic test_read_only();
    logic [31:0] r; int l; logic p;
    do_txn(0, 1'b1, 1'b0, 10'd0, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== ID) begin bad++; $display("FAIL ro_id got=%h want=%h", r, ID); end
    do_txn(0, 1'b0, 1'b1, 10'd0, 8'd0, 32'hFFFF_FFFF, 4'hF, r, l, p);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL ro_write_rdata got=%h want=0", r); end
    do_txn(0, 1'b1, 1'b0, 10'd0, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== ID) begin bad++; $display("FAIL ro_id_after_write got=%h want=%h", r, ID); end
    do_txn(0, 1'b1, 1'b0, 10'd2, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== CR) begin bad++; $display("FAIL ro_class got=%h want=%h", r, CR); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] r; int l; logic p;
    do_txn(0, 1'b0, 1'b1, 10'd4, 8'd0, 32'h1122_3344, 4'hF, r, l, p);
    do_txn(0, 1'b0, 1'b1, 10'd4, 8'd0, 32'hAABB_CCDD, 4'h5, r, l, p);
    do_txn(0, 1'b0, 1'b1, 10'd4, 8'd0, 32'hFFFF_FFFF, 4'h0, r, l, p);
    model_write(0, 10'd4, 8'd0, 32'h1122_3344, 4'hF);
    model_write(0, 10'd4, 8'd0, 32'hAABB_CCDD, 4'h5);
    do_txn(0, 1'b1, 1'b0, 10'd4, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'h11BB_33DD) begin bad++; $display("FAIL byte_enable got=%h want=11bb33dd", r); end
  endtask

  task automatic test_latency();
    logic [31:0] r; int l; logic p;
    for (int u = 0; u < 2; u++) begin
      do_txn(u, 1'b1, 1'b0, 10'd0, 8'd0, 32'd0, 4'h0, r, l, p);
      total++; if (l != lat_of[u]) begin bad++; $display("FAIL latency_read u%0d got=%0d want=%0d", u, l, lat_of[u]); end
      total++; if (r !== ID) begin bad++; $display("FAIL latency_rdata u%0d got=%h want=%h", u, r, ID); end
      do_txn(u, 1'b0, 1'b1, 10'd9, 8'd0, 32'h0BAD_CAFE, 4'hF, r, l, p);
      model_write(u, 10'd9, 8'd0, 32'h0BAD_CAFE, 4'hF);
      total++; if (l != lat_of[u]) begin bad++; $display("FAIL latency_write u%0d got=%0d want=%0d", u, l, lat_of[u]); end
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    logic [31:0] r = '0;
    @(negedge clk);
    addr_s[0] = 10'd9; func_s[0] = 8'd0; rd_s[0] = 1'b1; wr_s[0] = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= lat_of[0] + 3; k++) begin
      @(posedge clk); #1;
      if (done_s[0]) begin pulses++; r = rdata_s[0]; end
    end
    @(negedge clk); rd_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done_s[0]) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
    total++; if (r !== model_read(0, 10'd9, 8'd0)) begin bad++; $display("FAIL hold_rdata got=%h want=%h", r, model_read(0, 10'd9, 8'd0)); end
    total++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL hold_busy_release got=%b want=0", busy_s[0]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r; int l; logic p;
    do_txn(0, 1'b0, 1'b1, 10'd63, 8'd0, 32'hCAFE_F00D, 4'hF, r, l, p);
    model_write(0, 10'd63, 8'd0, 32'hCAFE_F00D, 4'hF);
    do_txn(0, 1'b1, 1'b0, 10'h3FF, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'd0 || l != lat_of[0]) begin bad++; $display("FAIL oor_read got=%h/%0d want=0/%0d", r, l, lat_of[0]); end
    do_txn(0, 1'b1, 1'b0, 10'd4, 8'd1, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'd0 || l != lat_of[0]) begin bad++; $display("FAIL func1_read got=%h/%0d want=0/%0d", r, l, lat_of[0]); end
    do_txn(0, 1'b0, 1'b1, 10'h3FF, 8'd0, 32'h1234_5678, 4'hF, r, l, p);
    total++; if (l != lat_of[0]) begin bad++; $display("FAIL oor_write_done got=%0d want=%0d", l, lat_of[0]); end
    do_txn(0, 1'b0, 1'b1, 10'd63, 8'd1, 32'h8765_4321, 4'hF, r, l, p);
    do_txn(0, 1'b1, 1'b0, 10'd63, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (r !== 32'hCAFE_F00D) begin bad++; $display("FAIL oor_alias got=%h want=cafef00d", r); end
  endtask

  task automatic test_collision();
    logic [31:0] r; int l; logic p;
    do_txn(0, 1'b1, 1'b1, 10'd6, 8'd0, 32'h0000_005A, 4'hF, r, l, p);
    model_write(0, 10'd6, 8'd0, 32'h0000_005A, 4'hF);
    total++; if (p !== 1'b1) begin bad++; $display("FAIL collision_perr got=%b want=1", p); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL collision_rdata got=%h want=0", r); end
    do_txn(0, 1'b1, 1'b0, 10'd6, 8'd0, 32'd0, 4'h0, r, l, p);
    total++; if (p !== 1'b0) begin bad++; $display("FAIL plain_perr got=%b want=0", p); end
    total++; if (r !== 32'h0000_005A) begin bad++; $display("FAIL collision_read got=%h want=5a", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, d, er; int l, u, sel; logic p, rd, wr;
    logic [9:0] a; logic [7:0] f; logic [3:0] b;
    for (int n = 0; n < 60; n++) begin
      u = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      rd = (sel <= 3) || (sel >= 8);
      wr = (sel >= 4) && (sel <= 8);
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 10'h3FF : (sel == 1) ? 10'($urandom) : 10'($urandom_range(0, 66));
      f = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      d = $urandom;
      b = 4'($urandom);
      er = wr ? 32'd0 : model_read(u, a, f);
      if (wr) model_write(u, a, f, d, b);
      do_txn(u, rd, wr, a, f, d, b, r, l, p);
      total++;
      if (r !== er || l != lat_of[u] || p !== (rd & wr)) begin
        bad++;
        $display("FAIL random n%0d u%0d a=%h rd=%b wr=%b got=%h/%0d/%b want=%h/%0d/%b",
                 n, u, a, rd, wr, r, l, p, er, lat_of[u], rd & wr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    lat_of[0] = 4;
    lat_of[1] = 1;
    for (int u = 0; u < 2; u++) begin
      addr_s[u] = '0; func_s[u] = '0; wd_s[u] = '0; be_s[u] = '0;
    end
    rd_s = '0;
    wr_s = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_reset_mid();
    test_read_only();
    test_byte_enable();
    test_latency();
    test_hold();
    test_out_of_range();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
